// File: rtl/otter_iobus_if.sv
// IOBUS bundle between the Otter core (master) and its memory-mapped I/O responder (slave).
interface otter_iobus_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input  IOBUS_IN);
  modport slave  (input  IOBUS_ADDR, input  IOBUS_OUT, input  IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/otter_iobus_peripheral.sv
// Otter IOBUS responder: switch/LED/seven-segment registers plus a prescaled compare timer.
// Read data is registered and reflects state before any same-cycle write.
module otter_iobus_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int          PRESCALE  = 1,
  parameter int          SW_WIDTH  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  otter_iobus_if.slave        bus,
  input  logic [SW_WIDTH-1:0] SWITCHES,
  output logic [SW_WIDTH-1:0] LEDS,
  output logic [15:0]         SSEG,
  output logic                INTR
);

  localparam logic [5:0]  OFF_SW    = 6'h00;
  localparam logic [5:0]  OFF_LED   = 6'h08;
  localparam logic [5:0]  OFF_SSEG  = 6'h10;
  localparam logic [5:0]  OFF_TCTRL = 6'h18;
  localparam logic [5:0]  OFF_TCMP  = 6'h19;
  localparam logic [5:0]  OFF_TCNT  = 6'h1A;
  localparam logic [5:0]  OFF_TSTAT = 6'h1B;
  localparam logic [31:0] PRE_LAST  = 32'(PRESCALE - 1);

  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [SW_WIDTH-1:0] led_q, led_d;
  logic [15:0]         sseg_q, sseg_d;
  logic                en_q, en_d, auto_q, auto_d, ie_q, ie_d, pend_q, pend_d;
  logic [31:0]         tcmp_q, tcmp_d, tcnt_q, tcnt_d, pre_q, pre_d;
  logic [31:0]         rd_q, rd_d;

  logic       in_region, wr_hit, tick, cmp_hit;
  logic [5:0] word_off;
  logic       wr_led, wr_sseg, wr_tctrl, wr_tcmp, wr_tcnt, wr_tstat;

  assign in_region = (bus.IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
  assign word_off  = bus.IOBUS_ADDR[7:2];
  assign wr_hit    = bus.IOBUS_WR & in_region;
  assign wr_led    = wr_hit & (word_off == OFF_LED);
  assign wr_sseg   = wr_hit & (word_off == OFF_SSEG);
  assign wr_tctrl  = wr_hit & (word_off == OFF_TCTRL);
  assign wr_tcmp   = wr_hit & (word_off == OFF_TCMP);
  assign wr_tcnt   = wr_hit & (word_off == OFF_TCNT);
  assign wr_tstat  = wr_hit & (word_off == OFF_TSTAT);

  assign tick    = en_q & (pre_q == PRE_LAST);
  assign cmp_hit = tick & (tcnt_q == tcmp_q);

  always_comb begin
    rd_d = '0;
    if (in_region) begin
      case (word_off)
        OFF_SW:    rd_d = 32'(sw_sync_q);
        OFF_LED:   rd_d = 32'(led_q);
        OFF_SSEG:  rd_d = {16'h0000, sseg_q};
        OFF_TCTRL: rd_d = {29'd0, ie_q, auto_q, en_q};
        OFF_TCMP:  rd_d = tcmp_q;
        OFF_TCNT:  rd_d = tcnt_q;
        OFF_TSTAT: rd_d = {31'd0, pend_q};
        default:   rd_d = '0;
      endcase
    end
  end

  always_comb begin
    led_d  = wr_led  ? bus.IOBUS_OUT[SW_WIDTH-1:0] : led_q;
    sseg_d = wr_sseg ? bus.IOBUS_OUT[15:0]         : sseg_q;
    tcmp_d = wr_tcmp ? bus.IOBUS_OUT               : tcmp_q;
    pre_d  = (!en_q || tick || wr_tcnt) ? '0 : pre_q + 32'd1;
    tcnt_d = tcnt_q;
    en_d   = en_q;
    auto_d = auto_q;
    ie_d   = ie_q;
    pend_d = pend_q;
    if (tick) begin
      if (cmp_hit) begin
        if (auto_q) tcnt_d = '0;
        else        en_d   = 1'b0;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
    // CPU writes are applied last so they override the timer's own update
    if (wr_tcnt)  tcnt_d = bus.IOBUS_OUT;
    if (wr_tctrl) {ie_d, auto_d, en_d} = bus.IOBUS_OUT[2:0];
    if (wr_tstat && bus.IOBUS_OUT[0]) pend_d = 1'b0;
    if (cmp_hit) pend_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      sseg_q    <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      tcmp_q    <= '0;
      tcnt_q    <= '0;
      pre_q     <= '0;
      rd_q      <= '0;
    end else begin
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      sseg_q    <= sseg_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      tcmp_q    <= tcmp_d;
      tcnt_q    <= tcnt_d;
      pre_q     <= pre_d;
      rd_q      <= rd_d;
    end
  end

  assign bus.IOBUS_IN = rd_q;
  assign LEDS         = led_q;
  assign SSEG         = sseg_q;
  assign INTR         = pend_q & ie_q;

endmodule

// File: tb/tb_otter_iobus_peripheral.sv
// Randomised + directed bench for otter_iobus_peripheral against a cycle-level behavioural model.
module tb_otter_iobus_peripheral;
  localparam logic [31:0] BASE  = 32'h1100_0000;
  localparam int          PRESC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw  = '0;
  logic [15:0] leds, sseg;
  logic        intr;
  int          n_chk = 0;
  int          n_err = 0;

  otter_iobus_if bus();

  otter_iobus_peripheral #(.BASE_ADDR(BASE), .PRESCALE(PRESC), .SW_WIDTH(16)) dut (
    .CLK(clk), .RST(rst), .bus(bus), .SWITCHES(sw), .LEDS(leds), .SSEG(sseg), .INTR(intr)
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0] m_in, m_cmp, m_cnt;
  logic [15:0] m_led, m_sseg, m_sw1, m_sw2;
  bit          m_en, m_auto, m_ie, m_pend;
  int          m_since;   // cycles elapsed in the current prescale period

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [31:0] a, input logic [31:0] d, input bit w,
                            input logic [15:0] s);
    logic [31:0] rd;
    bit          mapped, tick, hit;
    int          off;
    if (r) begin
      m_in = 0; m_cmp = 0; m_cnt = 0; m_led = 0; m_sseg = 0; m_sw1 = 0; m_sw2 = 0;
      m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_since = 0;
      return;
    end
    mapped = (a[31:8] == BASE[31:8]);
    off    = int'(a[7:0]) & 'hFC;
    rd = 0;
    if (mapped) begin
      case (off)
        'h00: rd = {16'h0, m_sw2};
        'h20: rd = {16'h0, m_led};
        'h40: rd = {16'h0, m_sseg};
        'h60: rd = {29'd0, m_ie, m_auto, m_en};
        'h64: rd = m_cmp;
        'h68: rd = m_cnt;
        'h6C: rd = {31'd0, m_pend};
        default: rd = 0;
      endcase
    end
    tick = m_en && (m_since + 1 == PRESC);
    hit  = tick && (m_cnt == m_cmp);
    m_since = (!m_en || tick) ? 0 : m_since + 1;
    if (hit) begin
      if (m_auto) m_cnt = 0; else m_en = 0;
    end else if (tick) m_cnt = m_cnt + 1;
    if (w && mapped) begin
      case (off)
        'h20: m_led  = d[15:0];
        'h40: m_sseg = d[15:0];
        'h60: begin m_en = d[0]; m_auto = d[1]; m_ie = d[2]; end
        'h64: m_cmp  = d;
        'h68: begin m_cnt = d; m_since = 0; end
        'h6C: if (d[0]) m_pend = 0;
        default: ;
      endcase
    end
    if (hit) m_pend = 1;
    m_sw2 = m_sw1;
    m_sw1 = s;
    m_in  = rd;
  endtask

  task automatic bus_cycle(input bit r, input logic [31:0] a, input logic [31:0] d, input bit w);
    rst = r; bus.IOBUS_ADDR = a; bus.IOBUS_OUT = d; bus.IOBUS_WR = w;
    @(posedge clk);
    model_step(r, a, d, w, sw);
    #1;
    chk("iobus_in", bus.IOBUS_IN, m_in);
    chk("leds", {16'h0, leds}, {16'h0, m_led});
    chk("sseg", {16'h0, sseg}, {16'h0, m_sseg});
    chk("intr", {31'd0, intr}, {31'd0, (m_pend & m_ie)});
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus_cycle(1'b0, BASE + 32'(off), d, 1'b1);
  endtask

  task automatic rd(input logic [7:0] off);
    bus_cycle(1'b0, BASE + 32'(off), 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic timer_clear();
    wr(8'h60, 0); wr(8'h6C, 1); wr(8'h68, 0);
  endtask

  initial begin
    logic [7:0]  offs [9] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h64, 8'h68, 8'h6C, 8'h04, 8'h7C};
    logic [31:0] a, d;
    bus.IOBUS_ADDR = 0; bus.IOBUS_OUT = 0; bus.IOBUS_WR = 0;
    #2;
    bus_cycle(1'b1, 0, 0, 1'b0);
    bus_cycle(1'b1, 0, 0, 1'b0);
    chk("rst_iobus_in", bus.IOBUS_IN, 0);
    chk("rst_intr", {31'd0, intr}, 0);

    wr(8'h20, 32'h0000_A5A5);
    chk("led_write", {16'h0, leds}, 32'hA5A5);
    wr(8'h40, 32'h0000_1234);
    chk("sseg_write", {16'h0, sseg}, 32'h1234);
    rd(8'h20); chk("led_read", bus.IOBUS_IN, 32'h0000_A5A5);
    rd(8'h40); chk("sseg_read", bus.IOBUS_IN, 32'h0000_1234);
    bus_cycle(1'b0, BASE + 32'h21, 0, 1'b0);
    chk("low_bits_ignored", bus.IOBUS_IN, 32'h0000_A5A5);

    #3 sw = 16'h00F0;
    idle(); idle(); rd(8'h00);
    chk("sw_sync", bus.IOBUS_IN, 32'h0000_00F0);
    rd(8'h04); chk("unmapped_rd", bus.IOBUS_IN, 0);
    bus_cycle(1'b0, 32'h1200_0000, 0, 1'b0); chk("out_region_rd", bus.IOBUS_IN, 0);
    bus_cycle(1'b0, 32'h1200_0020, 32'h1111, 1'b1); chk("out_region_wr", {16'h0, leds}, 32'hA5A5);
    wr(8'h00, 32'hFFFF_FFFF); rd(8'h00);
    chk("sw_wr_ignored", bus.IOBUS_IN, 32'h0000_00F0);
    chk("sw_wr_led", {16'h0, leds}, 32'hA5A5);

    // auto-reload, TCMP=4: period of 5
    wr(8'h64, 4); wr(8'h68, 0); wr(8'h60, 7);
    for (int i = 0; i < 6; i++) begin
      rd(8'h68);
      chk("tcnt_seq", bus.IOBUS_IN, 32'(i % 5));
      chk("intr_seq", {31'd0, intr}, (i >= 4) ? 1 : 0);
    end
    wr(8'h6C, 1); chk("w1c_intr", {31'd0, intr}, 0);
    idle(); idle();
    chk("intr_pre_period", {31'd0, intr}, 0);
    idle();
    chk("intr_second_period", {31'd0, intr}, 1);

    // one-shot
    timer_clear(); wr(8'h64, 2); wr(8'h60, 5);
    for (int i = 0; i < 4; i++) idle();
    rd(8'h60); chk("oneshot_en", bus.IOBUS_IN, 4);
    rd(8'h68); chk("oneshot_hold", bus.IOBUS_IN, 2);
    chk("oneshot_intr", {31'd0, intr}, 1);
    wr(8'h6C, 1);
    for (int i = 0; i < 6; i++) idle();
    chk("oneshot_no_repeat", {31'd0, intr}, 0);

    // W1C landing exactly on the compare hit
    timer_clear(); wr(8'h64, 2); wr(8'h60, 7); idle(); idle(); wr(8'h6C, 1);
    chk("w1c_vs_hit", {31'd0, intr}, 1);

    // wrap from all-ones
    timer_clear(); wr(8'h6C, 1); wr(8'h64, 5); wr(8'h68, 32'hFFFF_FFFF); wr(8'h60, 1);
    idle(); rd(8'h68); chk("tcnt_wrap", bus.IOBUS_IN, 0);
    for (int i = 0; i < 6; i++) idle();
    rd(8'h6C); chk("wrap_pend", bus.IOBUS_IN, 1);

    // write during tick
    wr(8'h6C, 1); wr(8'h60, 3); idle(); wr(8'h68, 100); rd(8'h68);
    chk("tcnt_wr_wins", bus.IOBUS_IN, 100);

    // reset mid-count with pending interrupt
    timer_clear(); wr(8'h64, 2); wr(8'h60, 7);
    for (int i = 0; i < 4; i++) idle();
    chk("pre_rst_intr", {31'd0, intr}, 1);
    bus_cycle(1'b1, BASE + 32'h20, 32'hFFFF, 1'b1);
    chk("rst_intr_mid", {31'd0, intr}, 0);
    chk("rst_in_mid", bus.IOBUS_IN, 0);
    chk("rst_led_mid", {16'h0, leds}, 0);
    rd(8'h68); idle(); idle(); idle();
    rd(8'h68); chk("rst_tcnt_idle", bus.IOBUS_IN, 0);
    rd(8'h60); chk("rst_tctrl", bus.IOBUS_IN, 0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) sw = 16'($urandom);
      a = BASE + 32'(offs[$urandom_range(0, 8)]) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0100_0000;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
      if (a[7:0] == 8'h60 && $urandom_range(0, 1) == 1) d = d | 32'h1;
      bus_cycle(($urandom_range(0, 99) == 0), a, d, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/otter_iobus_peripheral.md
Name: otter_iobus_peripheral

Overview:
Memory-mapped I/O responder on the far end of the Otter CPU's IOBUS. Decodes IOBUS_ADDR/IOBUS_OUT/IOBUS_WR from the core and returns read data on IOBUS_IN. Holds board-facing registers (switches, LEDs, seven-segment) and a programmable compare timer. The timer drives the core's INTR input.

Parameters:
BASE_ADDR, 32'h1100_0000, base of the peripheral region; decode compares IOBUS_ADDR[31:8] to BASE_ADDR[31:8].
PRESCALE, 1, CLK cycles per timer tick (>=1).
SW_WIDTH, 16, width of switch input and LED register.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
IOBUS_ADDR  input  32  byte address from the CPU.
IOBUS_OUT  input  32  write data from the CPU.
IOBUS_WR  input  1  write strobe; one write per cycle it is high.
IOBUS_IN  output  32  registered read data to the CPU.
SWITCHES  input  SW_WIDTH  asynchronous board switches.
LEDS  output  SW_WIDTH  LED register.
SSEG  output  16  seven-segment display value register.
INTR  output  1  level interrupt to the CPU.

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0x00 SW, read-only: synchronised switches, zero-extended.
  - +0x20 LED, read/write: low SW_WIDTH bits.
  - +0x40 SSEG, read/write: low 16 bits.
  - +0x60 TCTRL, read/write: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); other bits read 0.
  - +0x64 TCMP, read/write, 32 bits.
  - +0x68 TCNT, read/write, 32 bits; a write loads the counter.
  - +0x6C TSTAT: bit0 PEND. Write 1 clears PEND; write 0 has no effect.
- Decode:
  - Exact word address; IOBUS_ADDR[1:0] is ignored.
  - Unmapped or out-of-region writes are ignored.
  - Unmapped or out-of-region reads return 0.
  - Writes to SW are ignored.
- Read latency: 1 cycle. IOBUS_IN at edge N+1 holds the register selected by IOBUS_ADDR at edge N. IOBUS_IN shows the value before any write in that same cycle (read-before-write).
- SWITCHES path: two-flop synchroniser, so a switch change is visible at SW after 2 edges and on IOBUS_IN after 3.
- Prescaler: tick asserts for 1 cycle every PRESCALE cycles while EN=1. When EN=0 the prescaler is held at 0. A write to TCNT also resets the prescaler.
- Timer behaviour on a tick:
  - TCNT == TCMP: PEND<=1. If AUTO=1, TCNT<=0 and EN stays set. If AUTO=0, TCNT holds and EN<=0 (one-shot).
  - Otherwise: TCNT<=TCNT+1, wrapping from 0xFFFF_FFFF to 0.
  - With AUTO=1 the period is (TCMP+1)*PRESCALE cycles.
- Simultaneous events:
  - CPU write to TCNT in a tick cycle: the write wins and no increment occurs.
  - CPU write to TCTRL in a hit cycle: the written EN wins.
  - Compare hit and W1C of PEND in the same cycle: set wins, so PEND=1.
- INTR = PEND & IE, driven from registers (no combinational path from IOBUS inputs).
- Reset (RST=1 at an edge, including mid-count or with PEND set) clears everything:
  - IOBUS_IN, LEDS, SSEG, TCTRL, TCMP, TCNT, PEND, prescaler and synchroniser go to 0.
  - INTR=0 the cycle after.
  - Writes presented during reset are discarded.

Test Plan:
- Reset, then write 0x0000_A5A5 to 0x1100_0020 and 0x0000_1234 to 0x1100_0040 → LEDS=0xA5A5 and SSEG=0x1234 one edge later. Reading back both addresses gives IOBUS_IN=0x0000_A5A5 and 0x0000_1234 one cycle after the address.
- Set SWITCHES=0x00F0 asynchronously, then read 0x1100_0000 → 0x0000_00F0 within 3 edges. Read 0x1100_0004 and 0x1200_0000 → 0. Write to 0x1100_0000 → SW and LEDS unchanged.
- PRESCALE=1, TCMP=4, TCTRL=0b111 → PEND/INTR rise 5 cycles after EN and every 5 cycles thereafter. TCNT sequence reads 0,1,2,3,4,0. Write 1 to 0x1100_006C → INTR drops next edge.
- One-shot with TCTRL=0b101, TCMP=2 → a single PEND, EN reads 0 afterwards, TCNT holds at 2, and no further PEND after a W1C.
- Corner cases:
  - W1C in the exact hit cycle → PEND stays 1.
  - TCNT=0xFFFF_FFFF with TCMP=5, EN=1 → TCNT wraps to 0 and PEND sets at 5.
  - Write TCNT=100 in a tick cycle → TCNT reads 100.
- Assert RST mid-count with PEND=1 and IE=1 → next edge: INTR=0, TCNT=0, TCTRL=0, IOBUS_IN=0. Timer stays idle after RST falls until reprogrammed.
